// File: rtl/sram_port_arbiter.sv
// Shares one single-ported SRAM between instruction-fetch and load/store ports; every access is grant -> ACCESS -> RESP, with done 2 cycles after the request is seen in IDLE.
// There is no ready handshake: a requester holds req until its done pulse and sees stall until then. The data port normally wins; the instruction port wins after waiting STARVE_LIM cycles.
module sram_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic [DATA_W/8-1:0]   d_web,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_di,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_done,
  output logic                  stall,
  output logic                  m_cs,
  output logic                  m_oe,
  output logic [DATA_W/8-1:0]   m_web,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_di,
  input  logic [DATA_W-1:0]     m_do
);
  localparam int WAIT_W = $clog2(STARVE_LIM + 1);
  localparam logic [WAIT_W-1:0] LIM = WAIT_W'(STARVE_LIM);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              own;
  logic [WAIT_W-1:0] i_wait;

  logic i_elig, d_elig, grant_i, grant_d, i_busy;

  // The port completing in RESP still holds req that cycle, so it must not re-win.
  always_comb begin
    i_elig  = i_req && !(state == RESP && !own);
    d_elig  = d_req && !(state == RESP && own);
    grant_i = (state != ACCESS) && i_elig && ((i_wait >= LIM) || !d_elig);
    grant_d = (state != ACCESS) && d_elig && !grant_i;
    i_busy  = (state != IDLE) && !own;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      own    <= 1'b0;
      i_wait <= '0;
      i_done <= 1'b0;
      d_done <= 1'b0;
      m_cs   <= 1'b0;
      m_oe   <= 1'b0;
      m_web  <= '1;
      m_addr <= '0;
      m_di   <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      m_cs   <= 1'b0;
      m_oe   <= 1'b0;
      m_web  <= '1;
      m_addr <= '0;
      m_di   <= '0;
      if (state == ACCESS) begin
        state  <= RESP;
        i_done <= !own;
        d_done <= own;
      end else if (grant_i || grant_d) begin
        state <= ACCESS;
        own   <= grant_d;
        m_cs  <= 1'b1;
        if (grant_d) begin
          m_addr <= d_addr;
          m_web  <= d_web;
          m_di   <= d_di;
          m_oe   <= (d_web == '1);
        end else begin
          m_addr <= i_addr;
          m_oe   <= 1'b1;
        end
      end else begin
        state <= IDLE;
      end
      if (grant_i)
        i_wait <= '0;
      else if (i_req && !i_busy && i_wait < LIM)
        i_wait <= i_wait + 1'b1;
    end
  end

  // Read data from the macro is returned the cycle after the access, which is RESP.
  assign i_rdata = m_do;
  assign d_rdata = m_do;
  assign stall   = (i_req && !i_done) || (d_req && !d_done);

  a_req_held: assert property (@(posedge clk) disable iff (rst)
    (state == ACCESS) |-> (own ? d_req : i_req));
endmodule
